// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for an RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives the ALU op code,
// operand/result selects and all datapath write enables, and resolves
// conditional branches from the ALU ZERO flag.
//
// Optional feature: define CONTROL_UNIT_ILLEGAL_TRAP_EN to compile in the
// TRAP state (unknown opcode or bad branch funct3 raises ILLEGAL). Without
// it, such instructions fall back to FETCH after DECODE and ILLEGAL is 0.
//
// STATE encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4,
// MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10,
// JALR_CALC 11, JALR_JUMP 12, LUI 13, TRAP 14.
module control_unit #(
  parameter bit ILLEGAL_HOLD = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic        ZERO,
  output logic        PC_WE,
  output logic        IR_WE,
  output logic        MEM_WE,
  output logic        RF_WE,
  output logic        ADR_SRC,
  output logic [1:0]  ALU_SRC_A,
  output logic [1:0]  ALU_SRC_B,
  output logic [1:0]  RESULT_SRC,
  output logic [2:0]  IMM_SRC,
  output logic [3:0]  ALU_OP,
  output logic        ILLEGAL,
  output logic [3:0]  STATE
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_JUMP = 4'd12,
    S_LUI       = 4'd13
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    , S_TRAP    = 4'd14
`endif
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  state_t     state;
  state_t     next_state;
  state_t     bad_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [3:0] exec_op;
  logic [3:0] branch_op;
  logic       branch_taken;
  logic       pc_we_d;
  logic       ir_we_d;
  logic       mem_we_d;
  logic       rf_we_d;
  logic       unused_instr_bits;

  assign opcode            = INSTR[6:0];
  assign funct3            = INSTR[14:12];
  assign funct7_b5         = INSTR[30];
  assign unused_instr_bits = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  assign bad_next = S_TRAP;
  assign ILLEGAL  = (state == S_TRAP) & ~RST;
`else
  // Without the trap, illegal encodings retire as a NOP (PC already advanced).
  localparam bit unused_hold = ILLEGAL_HOLD;
  assign bad_next = S_FETCH;
  assign ILLEGAL  = 1'b0;
`endif

  // State register; reset parks the FSM in FETCH immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_FETCH;
    else     state <= next_state;
  end

  // ALU op for R/I-type execution; SUB only exists for R-type, SRA for both.
  always_comb begin
    exec_op = OP_ADD;
    case (funct3)
      3'b000:  exec_op = (opcode == OPC_OP && funct7_b5) ? OP_SUB : OP_ADD;
      3'b001:  exec_op = OP_SLL;
      3'b010:  exec_op = OP_SLT;
      3'b011:  exec_op = OP_SLTU;
      3'b100:  exec_op = OP_XOR;
      3'b101:  exec_op = funct7_b5 ? OP_SRA : OP_SRL;
      3'b110:  exec_op = OP_OR;
      default: exec_op = OP_AND;
    endcase
  end

  // Branch compare op and taken decision from the ALU zero flag.
  always_comb begin
    branch_op = OP_SUB;
    case (funct3[2:1])
      2'b10:   branch_op = OP_SLT;
      2'b11:   branch_op = OP_SLTU;
      default: branch_op = OP_SUB;
    endcase
    branch_taken = (funct3[2] ? ~ZERO : ZERO) ^ funct3[0];
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    IMM_SRC = 3'b000;
    case (opcode)
      OPC_STORE:           IMM_SRC = 3'b001;
      OPC_BRANCH:          IMM_SRC = 3'b010;
      OPC_JAL:             IMM_SRC = 3'b011;
      OPC_LUI, OPC_AUIPC:  IMM_SRC = 3'b100;
      default:             IMM_SRC = 3'b000;
    endcase
  end

  // Next-state and per-state outputs; enables default low, ALU defaults to ADD.
  always_comb begin
    next_state = state;
    pc_we_d    = 1'b0;
    ir_we_d    = 1'b0;
    mem_we_d   = 1'b0;
    rf_we_d    = 1'b0;
    ADR_SRC    = 1'b0;
    ALU_SRC_A  = 2'b00;
    ALU_SRC_B  = 2'b00;
    RESULT_SRC = 2'b00;
    ALU_OP     = OP_ADD;
    case (state)
      S_FETCH: begin
        ir_we_d    = 1'b1;
        pc_we_d    = 1'b1;
        ALU_SRC_A  = 2'b00;
        ALU_SRC_B  = 2'b10;
        RESULT_SRC = 2'b10;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // OLD_PC + imm lands in ALU_OUT for branches, JAL and AUIPC.
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b01;
        case (opcode)
          OPC_LOAD, OPC_STORE: next_state = S_MEM_ADR;
          OPC_OP:              next_state = S_EXEC_R;
          OPC_OP_IMM:          next_state = S_EXEC_I;
          OPC_BRANCH:          next_state = (funct3[2:1] == 2'b01) ? bad_next : S_BRANCH;
          OPC_JAL:             next_state = S_JAL;
          OPC_JALR:            next_state = S_JALR_CALC;
          OPC_LUI:             next_state = S_LUI;
          OPC_AUIPC:           next_state = S_ALU_WB;
          default:             next_state = bad_next;
        endcase
      end
      S_MEM_ADR: begin
        ALU_SRC_A  = 2'b10;
        ALU_SRC_B  = 2'b01;
        next_state = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ADR_SRC    = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        rf_we_d    = 1'b1;
        RESULT_SRC = 2'b01;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        ADR_SRC    = 1'b1;
        mem_we_d   = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_SRC_A  = 2'b10;
        ALU_SRC_B  = 2'b00;
        ALU_OP     = exec_op;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALU_SRC_A  = 2'b10;
        ALU_SRC_B  = 2'b01;
        ALU_OP     = exec_op;
        next_state = S_ALU_WB;
      end
      S_LUI: begin
        ALU_SRC_A  = 2'b11;
        ALU_SRC_B  = 2'b01;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we_d    = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SRC_A  = 2'b10;
        ALU_SRC_B  = 2'b00;
        ALU_OP     = branch_op;
        pc_we_d    = branch_taken;
        next_state = S_FETCH;
      end
      S_JAL, S_JALR_JUMP: begin
        // Jump to the target held in ALU_OUT while computing the link value.
        pc_we_d    = 1'b1;
        ALU_SRC_A  = 2'b01;
        ALU_SRC_B  = 2'b10;
        next_state = S_ALU_WB;
      end
      S_JALR_CALC: begin
        ALU_SRC_A  = 2'b10;
        ALU_SRC_B  = 2'b01;
        next_state = S_JALR_JUMP;
      end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      S_TRAP: begin
        next_state = ILLEGAL_HOLD ? S_TRAP : S_FETCH;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // Write enables are killed combinationally while reset is held.
  assign PC_WE  = pc_we_d  & ~RST;
  assign IR_WE  = ir_we_d  & ~RST;
  assign MEM_WE = mem_we_d & ~RST;
  assign RF_WE  = rf_we_d  & ~RST;
  assign STATE  = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test of control_unit against a per-instruction
// schedule model (cycle sequence from the instruction class, outputs per phase).
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] INSTR = 32'd0;
  logic        ZERO = 1'b0;
  logic        PC_WE, IR_WE, MEM_WE, RF_WE, ADR_SRC, ILLEGAL;
  logic [1:0]  ALU_SRC_A, ALU_SRC_B, RESULT_SRC;
  logic [2:0]  IMM_SRC;
  logic [3:0]  ALU_OP, STATE;

  control_unit #(.ILLEGAL_HOLD(1'b1)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .ZERO(ZERO),
    .PC_WE(PC_WE), .IR_WE(IR_WE), .MEM_WE(MEM_WE), .RF_WE(RF_WE),
    .ADR_SRC(ADR_SRC), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .RESULT_SRC(RESULT_SRC), .IMM_SRC(IMM_SRC), .ALU_OP(ALU_OP),
    .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  // clock
  always #5 CLK = ~CLK;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEM_ADR = 4'd2;
  localparam logic [3:0] ST_MEM_READ = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXEC_R = 4'd6, ST_EXEC_I = 4'd7,  ST_ALU_WB = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9, ST_JAL = 4'd10,    ST_JALR_CALC = 4'd11;
  localparam logic [3:0] ST_JALR_JUMP = 4'd12, ST_LUI = 4'd13, ST_TRAP = 4'd14;

  typedef enum {P_FETCH, P_DECODE, P_ADDR, P_READ, P_LOADWB, P_WRITE, P_EXEC_R,
                P_EXEC_I, P_WB, P_BRANCH, P_JAL, P_JALR_CALC, P_JALR_JUMP,
                P_LUI, P_TRAP} phase_t;

  int     checks = 0;
  int     errors = 0;
  phase_t sched[$];
  phase_t cur_ph = P_FETCH;
  bit     mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // ---- model: schedule of phases per instruction class ----
  task automatic load(input logic [31:0] ins, input logic z);
    INSTR = ins;
    ZERO  = z;
    sched.delete();
    sched.push_back(P_FETCH);
    sched.push_back(P_DECODE);
    case (ins[6:0])
      7'b0000011: begin sched.push_back(P_ADDR); sched.push_back(P_READ); sched.push_back(P_LOADWB); end
      7'b0100011: begin sched.push_back(P_ADDR); sched.push_back(P_WRITE); end
      7'b0110011: begin sched.push_back(P_EXEC_R); sched.push_back(P_WB); end
      7'b0010011: begin sched.push_back(P_EXEC_I); sched.push_back(P_WB); end
      7'b1100011: begin
        if (ins[14:13] != 2'b01) sched.push_back(P_BRANCH);
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        else sched.push_back(P_TRAP);
`endif
      end
      7'b1101111: begin sched.push_back(P_JAL); sched.push_back(P_WB); end
      7'b1100111: begin sched.push_back(P_JALR_CALC); sched.push_back(P_JALR_JUMP); sched.push_back(P_WB); end
      7'b0110111: begin sched.push_back(P_LUI); sched.push_back(P_WB); end
      7'b0010111: sched.push_back(P_WB);
      default: begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        sched.push_back(P_TRAP);
`endif
      end
    endcase
  endtask

  function automatic logic [3:0] exp_exec_op(input logic [31:0] ins);
    logic r;
    r = (ins[6:0] == 7'b0110011);
    case (ins[14:12])
      3'b000:  return (r && ins[30]) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b1000;
      3'b010:  return 4'b0010;
      3'b011:  return 4'b0011;
      3'b100:  return 4'b0110;
      3'b101:  return ins[30] ? 4'b1010 : 4'b1001;
      3'b110:  return 4'b0101;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic [3:0] exp_branch_op(input logic [31:0] ins);
    case (ins[14:12])
      3'b100, 3'b101: return 4'b0010;
      3'b110, 3'b111: return 4'b0011;
      default:        return 4'b0001;
    endcase
  endfunction

  // beq/bge/bgeu taken on zero; bne/blt/bltu taken on nonzero
  function automatic logic exp_taken(input logic [31:0] ins, input logic z);
    case (ins[14:12])
      3'b000, 3'b101, 3'b111: return z;
      3'b001, 3'b100, 3'b110: return !z;
      default:                return 1'b0;
    endcase
  endfunction

  // bit 3 = immediate format is meaningful for this opcode
  function automatic logic [3:0] exp_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'b0100011:             return 4'b1001;
      7'b1100011:             return 4'b1010;
      7'b1101111:             return 4'b1011;
      7'b0110111, 7'b0010111: return 4'b1100;
      7'b0110011:             return 4'b0000;
      default:                return 4'b1000;
    endcase
  endfunction

  task automatic check_cycle(input phase_t ph, input logic [31:0] ins, input logic z);
    logic       e_pc, e_ir, e_mem, e_rf, e_ill;
    logic [3:0] e_st, ei;
    string      p;
    p = ph.name();
    e_pc = 0; e_ir = 0; e_mem = 0; e_rf = 0; e_ill = 0; e_st = ST_FETCH;
    case (ph)
      P_FETCH: begin
        e_pc = 1; e_ir = 1; e_st = ST_FETCH;
        chk({p, "_adr_src"}, 32'(ADR_SRC), 32'd0);
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd0);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd2);
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd2);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'd0);
      end
      P_DECODE: begin
        e_st = ST_DECODE;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd1);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd1);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'd0);
      end
      P_ADDR, P_JALR_CALC: begin
        e_st = (ph == P_ADDR) ? ST_MEM_ADR : ST_JALR_CALC;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd2);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd1);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'd0);
      end
      P_READ: begin
        e_st = ST_MEM_READ;
        chk({p, "_adr_src"}, 32'(ADR_SRC), 32'd1);
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd0);
      end
      P_LOADWB: begin
        e_rf = 1; e_st = ST_MEM_WB;
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd1);
      end
      P_WRITE: begin
        e_mem = 1; e_st = ST_MEM_WRITE;
        chk({p, "_adr_src"}, 32'(ADR_SRC), 32'd1);
      end
      P_EXEC_R, P_EXEC_I: begin
        e_st = (ph == P_EXEC_R) ? ST_EXEC_R : ST_EXEC_I;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd2);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), (ph == P_EXEC_R) ? 32'd0 : 32'd1);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'(exp_exec_op(ins)));
      end
      P_WB: begin
        e_rf = 1; e_st = ST_ALU_WB;
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd0);
      end
      P_BRANCH: begin
        e_pc = exp_taken(ins, z); e_st = ST_BRANCH;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd2);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd0);
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd0);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'(exp_branch_op(ins)));
      end
      P_JAL, P_JALR_JUMP: begin
        e_pc = 1; e_st = (ph == P_JAL) ? ST_JAL : ST_JALR_JUMP;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd1);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd2);
        chk({p, "_result_src"}, 32'(RESULT_SRC), 32'd0);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'd0);
      end
      P_LUI: begin
        e_st = ST_LUI;
        chk({p, "_src_a"}, 32'(ALU_SRC_A), 32'd3);
        chk({p, "_src_b"}, 32'(ALU_SRC_B), 32'd1);
        chk({p, "_alu_op"}, 32'(ALU_OP), 32'd0);
      end
      default: begin
        e_ill = 1; e_st = ST_TRAP;
      end
    endcase
    chk({p, "_pc_we"}, 32'(PC_WE), 32'(e_pc));
    chk({p, "_ir_we"}, 32'(IR_WE), 32'(e_ir));
    chk({p, "_mem_we"}, 32'(MEM_WE), 32'(e_mem));
    chk({p, "_rf_we"}, 32'(RF_WE), 32'(e_rf));
    chk({p, "_illegal"}, 32'(ILLEGAL), 32'(e_ill));
    chk({p, "_state"}, 32'(STATE), 32'(e_st));
    ei = exp_imm(ins);
    if (ei[3]) chk({p, "_imm_src"}, 32'(IMM_SRC), 32'(ei[2:0]));
  endtask

  // compare process: every cycle the schedule covers
  always @(negedge CLK) begin
    if (mon_en) check_cycle(cur_ph, INSTR, ZERO);
  end

  // ---- driver tasks ----
  // probe = {PC_WE, RF_WE, MEM_WE, ALU_OP} expected at the start of cycle probe_k
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
                           input int cpi, input int probe_k, input logic [6:0] probe);
    int n;
    n = 0;
    load(ins, z);
    do begin
      if (n == probe_k)
        chk({nm, "_probe"}, {25'd0, PC_WE, RF_WE, MEM_WE, ALU_OP}, {25'd0, probe});
      mon_en = (n < sched.size());
      if (mon_en) cur_ph = sched[n];
      @(posedge CLK);
      #1;
      n++;
    end while (STATE != ST_FETCH && n < 20);
    mon_en = 1'b0;
    chk({nm, "_cycles"}, 32'(n), 32'(cpi));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_state"}, 32'(STATE), 32'(ST_FETCH));
    chk({nm, "_we"}, {28'd0, PC_WE, IR_WE, MEM_WE, RF_WE}, 32'd0);
    chk({nm, "_illegal"}, 32'(ILLEGAL), 32'd0);
    chk({nm, "_selects"}, {25'd0, ADR_SRC, ALU_SRC_A, ALU_SRC_B, RESULT_SRC},
        {25'd0, 1'b0, 2'b00, 2'b10, 2'b10});
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // main sequence
  initial begin
    #1 RST = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(posedge CLK); #1;
    check_reset_outputs("reset_held");
    @(posedge CLK); #1;
    RST = 1'b0;

    run_instr("addi",     32'h00500093, 1'b0, 4, 2, 7'b000_0000);
    run_instr("addi_neg", 32'hC0000093, 1'b0, 4, 2, 7'b000_0000);
    run_instr("sub",      32'h402081B3, 1'b0, 4, 2, 7'b000_0001);
    run_instr("add",      32'h002081B3, 1'b0, 4, 3, 7'b010_0000);
    run_instr("sra",      32'h4020D1B3, 1'b0, 4, 2, 7'b000_1010);
    run_instr("srai",     32'h4030D193, 1'b0, 4, 2, 7'b000_1010);
    run_instr("srli",     32'h0030D193, 1'b0, 4, 2, 7'b000_1001);
    run_instr("sll",      32'h002091B3, 1'b0, 4, 2, 7'b000_1000);
    run_instr("slt",      32'h0020A1B3, 1'b0, 4, 2, 7'b000_0010);
    run_instr("sltu",     32'h0020B1B3, 1'b0, 4, 2, 7'b000_0011);
    run_instr("xor",      32'h0020C1B3, 1'b0, 4, 2, 7'b000_0110);
    run_instr("or",       32'h0020E1B3, 1'b0, 4, 2, 7'b000_0101);
    run_instr("and",      32'h0020F1B3, 1'b0, 4, 2, 7'b000_0100);
    run_instr("bne_z1",   32'h00209463, 1'b1, 3, 2, 7'b000_0001);
    run_instr("bne_z0",   32'h00209463, 1'b0, 3, 2, 7'b100_0001);
    run_instr("beq_z1",   32'h00208463, 1'b1, 3, 2, 7'b100_0001);
    run_instr("bltu_z0",  32'h0020E463, 1'b0, 3, 2, 7'b100_0011);
    run_instr("bltu_z1",  32'h0020E463, 1'b1, 3, 2, 7'b000_0011);
    run_instr("bge_z1",   32'h0020D463, 1'b1, 3, 2, 7'b100_0010);
    run_instr("lw",       32'h0000A183, 1'b0, 5, 4, 7'b010_0000);
    run_instr("sw",       32'h0020A023, 1'b0, 4, 3, 7'b001_0000);
    run_instr("jal",      32'h010000EF, 1'b0, 4, 2, 7'b100_0000);
    run_instr("jalr",     32'h000100E7, 1'b0, 5, 3, 7'b100_0000);
    run_instr("lui",      32'h123452B7, 1'b0, 4, 2, 7'b000_0000);
    run_instr("auipc",    32'h00001297, 1'b0, 3, 2, 7'b010_0000);

    // reset asserted in the middle of MEM_WRITE
    load(32'h0020A023, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cur_ph = sched[n];
      mon_en = 1'b1;
      @(posedge CLK); #1;
    end
    cur_ph = sched[3];
    @(negedge CLK); #2;
    mon_en = 1'b0;
    chk("sw_mem_we_before_rst", 32'(MEM_WE), 32'd1);
    RST = 1'b1;
    #1 check_reset_outputs("rst_mid_store");
    @(posedge CLK); #1;
    check_reset_outputs("rst_mid_store_edge");
    RST = 1'b0;
    run_instr("sw_restart", 32'h0020A023, 1'b0, 4, 3, 7'b001_0000);

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    // trap with hold: stays in TRAP until reset
    load(32'h0000007F, 1'b0);
    for (int n = 0; n < 14; n++) begin
      cur_ph = (n < 2) ? sched[n] : P_TRAP;
      mon_en = 1'b1;
      @(posedge CLK); #1;
    end
    mon_en = 1'b0;
    chk("trap_state_held", 32'(STATE), 32'(ST_TRAP));
    chk("trap_illegal_held", 32'(ILLEGAL), 32'd1);
    RST = 1'b1;
    #1 check_reset_outputs("trap_reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    run_instr("addi_after_trap", 32'h00500093, 1'b0, 4, 2, 7'b000_0000);
`else
    run_instr("opc_7f_nop",  32'h0000007F, 1'b0, 2, 1, 7'b000_0000);
    run_instr("bad_br_nop",  32'h0020A463, 1'b0, 2, 1, 7'b000_0000);
    run_instr("addi_after",  32'h00500093, 1'b0, 4, 2, 7'b000_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the RV32I core; sits directly upstream of the ALU. Decodes the instruction register, sequences fetch/decode/execute/memory/writeback, and drives the ALU operation code, operand selects, and every datapath write enable. Consumes the ALU `ZERO` flag to resolve conditional branches.

## Interface
- `ILLEGAL_HOLD`, default 1: with the trap compiled in, 1 = trap state held until reset; 0 = trap state lasts one cycle, then returns to FETCH.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `INSTR` in 32: instruction register contents.
- `ZERO` in 1: ALU zero flag.
- `PC_WE`, `IR_WE`, `MEM_WE`, `RF_WE` out 1 each: PC / IR+OLD_PC / memory / register-file write enables.
- `ADR_SRC` out 1: memory address select; 0 = PC, 1 = result bus.
- `ALU_SRC_A` out 2: 00 PC, 01 OLD_PC, 10 rs1 data, 11 zero.
- `ALU_SRC_B` out 2: 00 rs2 data, 01 immediate, 10 constant 4.
- `RESULT_SRC` out 2: 00 ALU_OUT register, 01 memory data register, 10 live ALU result.
- `IMM_SRC` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALU_OP` out 4: [3:2] 00 arith, 01 logic, 10 shift. Arith [1:0]: ADD 00, SUB 01, SLT 10, SLTU 11. Logic: AND 00, OR 01, XOR 10. Shift: SLL 00, SRL 01, SRA 10.
- `ILLEGAL` out 1: unknown opcode trapped.
- `STATE` out 4: current state, for debug.

## Operation
States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR_CALC, JALR_JUMP, LUI, TRAP.

- **FETCH:** ADR_SRC=0, IR_WE=1, SRC_A=PC, SRC_B=4, ADD, RESULT_SRC=10, PC_WE=1 → DECODE.
- **DECODE:** SRC_A=OLD_PC, SRC_B=imm, ADD (target latched in ALU_OUT). Next state by INSTR[6:0]:
  - 0000011 → MEM_ADR; 0100011 → MEM_ADR
  - 0110011 → EXEC_R; 0010011 → EXEC_I
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR_CALC
  - 0110111 → LUI; 0010111 → ALU_WB (AUIPC)
  - else → TRAP
- **MEM_ADR:** rs1+imm, ADD → MEM_READ for loads, MEM_WRITE for stores.
- **MEM_READ:** ADR_SRC=1, RESULT_SRC=00 → MEM_WB.
- **MEM_WB:** RF_WE=1, RESULT_SRC=01 → FETCH.
- **MEM_WRITE:** ADR_SRC=1, MEM_WE=1 → FETCH.
- **EXEC_R / EXEC_I:** operands rs1/rs2 or rs1/imm → ALU_WB. ALU op from funct3:
  - 000 → ADD; SUB only for R-type with funct7[5]=1
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
  - 101 → SRL, or SRA when funct7[5]=1 (both R and I)
  - 110 → OR; 111 → AND
- **LUI:** SRC_A=zero, SRC_B=imm, ADD → ALU_WB.
- **ALU_WB:** RF_WE=1, RESULT_SRC=00 → FETCH.
- **BRANCH:** rs1 vs rs2; op is SUB for funct3[2:1]=00, SLT for 10, SLTU for 11. Taken = ((funct3[2] ? ~ZERO : ZERO) ^ funct3[0]). PC_WE=taken, RESULT_SRC=00 → FETCH. funct3 010/011 → TRAP.
- **JAL / JALR_JUMP:** PC_WE=1, RESULT_SRC=00; ALU computes OLD_PC+4 → ALU_WB.
- **JALR_CALC:** rs1+imm → JALR_JUMP. Clearing bit 0 of the target is done in the datapath.
- IMM_SRC is combinational from opcode in every state; don't-care on unknown opcodes (drive 000).

## Timing
- Moore outputs from the state register. Exceptions, combinational from INSTR/ZERO: ALU_OP, IMM_SRC, and PC_WE in BRANCH.
- Cycles per instruction:
  - load 5; store 4; R/I 4
  - branch 3; JAL 4; JALR 5
  - LUI 4; AUIPC 3
- RST asserted: state = FETCH asynchronously. All four write enables, ILLEGAL, and MEM_WE are forced 0 while RST is high. Selects take their FETCH values. STATE = 0 (FETCH encoding).
- RST deasserted: first rising edge of CLK performs a fetch.
- RST mid-instruction: abandons the instruction; no partial write occurs after assertion.

## Configuration
- `CONTROL_UNIT_ILLEGAL_TRAP_EN` defined:
  - Unknown opcode or bad branch funct3 → TRAP, with all enables 0 and ILLEGAL=1.
  - ILLEGAL_HOLD=1: remains in TRAP until reset.
  - ILLEGAL_HOLD=0: one cycle, then FETCH.
- Undefined:
  - TRAP state does not exist; those cases go DECODE → FETCH (executed as NOP, PC already advanced).
  - ILLEGAL tied 0.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) → STATE FETCH, DECODE, EXEC_I, ALU_WB; RF_WE high only in cycle 4, ALU_OP=0000, ALU_SRC_B=01.
- `sub x3,x1,x2` (0x402081B3) → EXEC_R with ALU_OP=0001; `sra` funct7[5]=1 → 1010.
- `bne` with ZERO=1 → PC_WE=0 in BRANCH; with ZERO=0 → PC_WE=1; `bltu` drives ALU_OP=0011, taken when ZERO=0.
- `lw` → 5 cycles; ADR_SRC=1 in MEM_READ; RF_WE with RESULT_SRC=01 in MEM_WB. `sw` → MEM_WE high for exactly one cycle.
- Opcode 0x7F with macro defined and ILLEGAL_HOLD=1 → TRAP, ILLEGAL=1 held for 10+ cycles, no write enables. Without the macro → back to FETCH after DECODE.
- RST asserted during MEM_WRITE → MEM_WE drops immediately (asynchronously); after release, the instruction restarts in FETCH.
